// File: rtl/cell_draw_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cell_draw_tx_pkg
// Brief   : Shared types, colours, LCD commands and default geometry.
// Revision: 1.0
// ============================================================================
package cell_draw_tx_pkg;

  localparam int c_GRID_W_DEF  = 16;
  localparam int c_GRID_H_DEF  = 12;
  localparam int c_CELL_PX_DEF = 20;

  typedef enum logic [2:0] {
    OBJ_EMPTY  = 3'd0,
    OBJ_BODY   = 3'd1,
    OBJ_HEAD   = 3'd2,
    OBJ_APPLE  = 3'd3,
    OBJ_BORDER = 3'd4
  } obj_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic       dcx;
    logic [7:0] data;
  } lcd_byte_t;

  localparam logic [15:0] c_RGB_EMPTY   = 16'h0000;
  localparam logic [15:0] c_RGB_BODY    = 16'h07E0;
  localparam logic [15:0] c_RGB_HEAD    = 16'h03E0;
  localparam logic [15:0] c_RGB_APPLE   = 16'hF800;
  localparam logic [15:0] c_RGB_BORDER  = 16'h8410;
  localparam logic [15:0] c_RGB_UNKNOWN = 16'hF81F;
  localparam logic [15:0] c_RGB_OUTLINE = 16'h2104;

  localparam logic [7:0] c_CMD_CASET = 8'h2A;
  localparam logic [7:0] c_CMD_PASET = 8'h2B;
  localparam logic [7:0] c_CMD_RAMWR = 8'h2C;

  function automatic logic [15:0] obj_color(input logic [2:0] code);
    case (code)
      OBJ_EMPTY:  return c_RGB_EMPTY;
      OBJ_BODY:   return c_RGB_BODY;
      OBJ_HEAD:   return c_RGB_HEAD;
      OBJ_APPLE:  return c_RGB_APPLE;
      OBJ_BORDER: return c_RGB_BORDER;
      default:    return c_RGB_UNKNOWN;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/cell_draw_tx_if.sv
`default_nettype none
// ============================================================================
// Module  : cell_draw_tx_if
// Brief   : Scan-engine change handshake plus 8080 LCD write bus.
// Revision: 1.0
// ============================================================================
interface cell_draw_tx_if;
  logic       diff;
  logic [3:0] x;
  logic [3:0] y;
  logic [2:0] obj_code;
  logic       cmd_done;
  logic       busy;
  logic [7:0] lcd_d;
  logic       lcd_dcx;
  logic       lcd_wrx;
  logic       lcd_csx;

  modport master (
    output diff, x, y, obj_code,
    input  cmd_done, busy, lcd_d, lcd_dcx, lcd_wrx, lcd_csx
  );

  modport slave (
    input  diff, x, y, obj_code,
    output cmd_done, busy, lcd_d, lcd_dcx, lcd_wrx, lcd_csx
  );
endinterface
`default_nettype wire

// File: rtl/cell_draw_tx_lcd8080_byte_tx.sv
`default_nettype none
// ============================================================================
// Module  : lcd8080_byte_tx
// Brief   : Two-cycle 8080 byte writer: phase A strobes WRX low, phase B high.
// Revision: 1.0
// ============================================================================
module lcd8080_byte_tx
  import cell_draw_tx_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       valid_i,
  input  wire lcd_byte_t  req_i,
  output logic            ready_o,
  output logic [7:0]      lcd_d_o,
  output logic            lcd_dcx_o,
  output logic            lcd_wrx_o
);

  logic       wrx_q;
  logic [7:0] d_q;
  logic       dcx_q;

  // WRX high means phase B (or idle): the next byte may be launched now.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrx_q <= 1'b1;
      d_q   <= 8'h00;
      dcx_q <= 1'b1;
    end else if (!wrx_q) begin
      wrx_q <= 1'b1;
    end else if (valid_i) begin
      wrx_q <= 1'b0;
      d_q   <= req_i.data;
      dcx_q <= req_i.dcx;
    end
  end

  assign ready_o   = wrx_q;
  assign lcd_d_o   = d_q;
  assign lcd_dcx_o = dcx_q;
  assign lcd_wrx_o = wrx_q;

endmodule
`default_nettype wire

// File: rtl/cell_draw_tx.sv
`default_nettype none
// ============================================================================
// Module  : cell_draw_tx
// Brief   : Paints one grid cell as a CELL_PX square over an 8080 LCD bus.
//           Optional CELL_OUTLINE_EN draws the cell's last row/column as outline.
// Revision: 1.0
// ============================================================================
module cell_draw_tx
  import cell_draw_tx_pkg::*;
#(
  parameter int GRID_W  = c_GRID_W_DEF,
  parameter int GRID_H  = c_GRID_H_DEF,
  parameter int CELL_PX = c_CELL_PX_DEF
) (
  input  wire logic     clk,
  input  wire logic     rst,
  cell_draw_tx_if.slave bus
);

  localparam int PIX_N = CELL_PX * CELL_PX;
  localparam int PIX_W = $clog2(PIX_N);
  localparam int CNT_W = $clog2(CELL_PX);
  localparam logic [PIX_W-1:0] c_PIX_LAST = PIX_W'(PIX_N - 1);
  localparam logic [CNT_W-1:0] c_EDGE     = CNT_W'(CELL_PX - 1);

  state_e           state_q, state_d;
  logic [3:0]       x_q, x_d, y_q, y_d;
  logic [2:0]       obj_q, obj_d;
  logic [3:0]       idx_q, idx_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
  logic             lo_q, lo_d;
  logic             last_q, last_d;

  logic             tx_valid;
  logic             tx_ready;
  lcd_byte_t        tx_req;
  lcd_byte_t        hdr_req;
  logic [15:0]      x0, x1, y0, y1;
  logic [15:0]      pix_color;
  logic             in_range;
  logic [7:0]       lcd_d;
  logic             lcd_dcx;
  logic             lcd_wrx;

  assign x0 = 16'(x_q) * 16'(CELL_PX);
  assign x1 = x0 + 16'(CELL_PX - 1);
  assign y0 = 16'(y_q) * 16'(CELL_PX);
  assign y1 = y0 + 16'(CELL_PX - 1);

  assign in_range = (int'(bus.x) < GRID_W) && (int'(bus.y) < GRID_H);

  // Byte 0 (CASET) is launched from IDLE, so this table starts at index 1.
  always_comb begin
    hdr_req = '{dcx: 1'b0, data: c_CMD_CASET};
    case (idx_q)
      4'd1:    hdr_req = '{dcx: 1'b1, data: x0[15:8]};
      4'd2:    hdr_req = '{dcx: 1'b1, data: x0[7:0]};
      4'd3:    hdr_req = '{dcx: 1'b1, data: x1[15:8]};
      4'd4:    hdr_req = '{dcx: 1'b1, data: x1[7:0]};
      4'd5:    hdr_req = '{dcx: 1'b0, data: c_CMD_PASET};
      4'd6:    hdr_req = '{dcx: 1'b1, data: y0[15:8]};
      4'd7:    hdr_req = '{dcx: 1'b1, data: y0[7:0]};
      4'd8:    hdr_req = '{dcx: 1'b1, data: y1[15:8]};
      4'd9:    hdr_req = '{dcx: 1'b1, data: y1[7:0]};
      4'd10:   hdr_req = '{dcx: 1'b0, data: c_CMD_RAMWR};
      default: hdr_req = '{dcx: 1'b0, data: c_CMD_CASET};
    endcase
  end

  always_comb begin
    pix_color = obj_color(obj_q);
`ifdef CELL_OUTLINE_EN
    if ((obj_q != OBJ_EMPTY) && ((col_q == c_EDGE) || (row_q == c_EDGE))) begin
      pix_color = c_RGB_OUTLINE;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    obj_d    = obj_q;
    idx_d    = idx_q;
    pix_d    = pix_q;
    col_d    = col_q;
    row_d    = row_q;
    lo_d     = lo_q;
    last_d   = last_q;
    tx_valid = 1'b0;
    tx_req   = '{dcx: 1'b1, data: 8'h00};

    case (state_q)
      ST_IDLE: begin
        idx_d  = 4'd1;
        pix_d  = '0;
        col_d  = '0;
        row_d  = '0;
        lo_d   = 1'b0;
        last_d = 1'b0;
        if (bus.diff) begin
          x_d   = bus.x;
          y_d   = bus.y;
          obj_d = bus.obj_code;
          if (in_range) begin
            tx_valid = 1'b1;
            tx_req   = '{dcx: 1'b0, data: c_CMD_CASET};
            state_d  = ST_HDR;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_HDR: begin
        tx_valid = 1'b1;
        tx_req   = hdr_req;
        if (tx_ready) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd10) state_d = ST_PIX;
        end
      end

      ST_PIX: begin
        tx_valid = !last_q;
        tx_req   = '{dcx: 1'b1, data: lo_q ? pix_color[7:0] : pix_color[15:8]};
        // Once the final byte is launched, wait for its phase B before DONE.
        if (tx_ready) begin
          if (last_q) begin
            state_d = ST_DONE;
          end else if (lo_q) begin
            lo_d  = 1'b0;
            pix_d = pix_q + PIX_W'(1);
            if (pix_q == c_PIX_LAST) last_d = 1'b1;
            if (col_q == c_EDGE) begin
              col_d = '0;
              row_d = (row_q == c_EDGE) ? '0 : row_q + CNT_W'(1);
            end else begin
              col_d = col_q + CNT_W'(1);
            end
          end else begin
            lo_d = 1'b1;
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      obj_q   <= '0;
      idx_q   <= '0;
      pix_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      lo_q    <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      obj_q   <= obj_d;
      idx_q   <= idx_d;
      pix_q   <= pix_d;
      col_q   <= col_d;
      row_q   <= row_d;
      lo_q    <= lo_d;
      last_q  <= last_d;
    end
  end

  lcd8080_byte_tx u_byte_tx (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (tx_valid),
    .req_i     (tx_req),
    .ready_o   (tx_ready),
    .lcd_d_o   (lcd_d),
    .lcd_dcx_o (lcd_dcx),
    .lcd_wrx_o (lcd_wrx)
  );

  assign bus.lcd_d    = lcd_d;
  assign bus.lcd_dcx  = lcd_dcx;
  assign bus.lcd_wrx  = lcd_wrx;
  assign bus.lcd_csx  = !((state_q == ST_HDR) || (state_q == ST_PIX));
  assign bus.cmd_done = (state_q == ST_DONE);
  assign bus.busy     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cell_draw_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_cell_draw_tx
// Brief   : Scoreboard bench for cell_draw_tx against a geometric paint model.
// Revision: 1.0
// ============================================================================
module tb_cell_draw_tx;

  typedef struct {
    bit       dcx;
    bit [7:0] data;
    int       cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  bit   rst_seen = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   bytes_seen = 0;
  exp_t exp_b[$];
  int   exp_d[$];
  bit   prev_low = 1'b0;
  bit [8:0] prev_byte = '0;

  cell_draw_tx_if bus ();

  cell_draw_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  function automatic bit [15:0] ref_color(int obj, int r, int c);
    bit [15:0] col;
    case (obj)
      0: col = 16'h0000;
      1: col = 16'h07E0;
      2: col = 16'h03E0;
      3: col = 16'hF800;
      4: col = 16'h8410;
      default: col = 16'hF81F;
    endcase
`ifdef CELL_OUTLINE_EN
    if (obj != 0 && (r == 19 || c == 19)) col = 16'h2104;
`endif
    return col;
  endfunction

  function automatic void push_byte(bit dcx, bit [7:0] data, int t);
    exp_t e;
    e.dcx = dcx; e.data = data; e.cyc = t;
    exp_b.push_back(e);
  endfunction

  // Expected bus traffic for a request whose diff is sampled in cycle t0.
  function automatic void model(int px, int py, int obj, int t0);
    int k;
    bit [15:0] x0, x1, y0, y1, col;
    if (px >= 16 || py >= 12) begin
      exp_d.push_back(t0 + 1);
      return;
    end
    x0 = 16'(px * 20); x1 = 16'(px * 20 + 19);
    y0 = 16'(py * 20); y1 = 16'(py * 20 + 19);
    k = 0;
    push_byte(1'b0, 8'h2A, t0 + 1 + 2*k); k++;
    push_byte(1'b1, x0[15:8], t0 + 1 + 2*k); k++;
    push_byte(1'b1, x0[7:0], t0 + 1 + 2*k); k++;
    push_byte(1'b1, x1[15:8], t0 + 1 + 2*k); k++;
    push_byte(1'b1, x1[7:0], t0 + 1 + 2*k); k++;
    push_byte(1'b0, 8'h2B, t0 + 1 + 2*k); k++;
    push_byte(1'b1, y0[15:8], t0 + 1 + 2*k); k++;
    push_byte(1'b1, y0[7:0], t0 + 1 + 2*k); k++;
    push_byte(1'b1, y1[15:8], t0 + 1 + 2*k); k++;
    push_byte(1'b1, y1[7:0], t0 + 1 + 2*k); k++;
    push_byte(1'b0, 8'h2C, t0 + 1 + 2*k); k++;
    for (int r = 0; r < 20; r++) begin
      for (int c = 0; c < 20; c++) begin
        col = ref_color(obj, r, c);
        push_byte(1'b1, col[15:8], t0 + 1 + 2*k); k++;
        push_byte(1'b1, col[7:0], t0 + 1 + 2*k); k++;
      end
    end
    exp_d.push_back(t0 + 1623);
  endfunction

  // Monitor / scoreboard: all comparisons live here.
  always @(negedge clk) begin
    if (rst_seen) begin
      exp_b.delete();
      exp_d.delete();
      prev_low = 1'b0;
      checks++;
      if ({bus.lcd_csx, bus.lcd_wrx, bus.lcd_dcx, bus.lcd_d, bus.cmd_done, bus.busy}
          !== {1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0}) begin
        failures++;
        if (failures <= 40)
          $display("FAIL reset_outputs cyc=%0d got csx=%b wrx=%b dcx=%b d=%h done=%b busy=%b required 1 1 1 00 0 0",
                   cyc, bus.lcd_csx, bus.lcd_wrx, bus.lcd_dcx, bus.lcd_d, bus.cmd_done, bus.busy);
      end
    end else begin
      if (prev_low) begin
        checks++;
        if (bus.lcd_wrx !== 1'b1 || {bus.lcd_dcx, bus.lcd_d} !== prev_byte) begin
          failures++;
          if (failures <= 40)
            $display("FAIL phase_b_hold cyc=%0d got wrx=%b dcx/d=%h required wrx=1 dcx/d=%h",
                     cyc, bus.lcd_wrx, {bus.lcd_dcx, bus.lcd_d}, prev_byte);
        end
      end
      if (bus.lcd_wrx === 1'b0) begin
        bytes_seen++;
        checks++;
        if (exp_b.size() == 0) begin
          failures++;
          if (failures <= 40)
            $display("FAIL unexpected_strobe cyc=%0d got dcx/d=%h required no write", cyc, {bus.lcd_dcx, bus.lcd_d});
        end else begin
          exp_t e;
          e = exp_b.pop_front();
          if ({bus.lcd_dcx, bus.lcd_d} !== {e.dcx, e.data} || cyc != e.cyc || bus.lcd_csx !== 1'b0) begin
            failures++;
            if (failures <= 40)
              $display("FAIL lcd_byte cyc=%0d got dcx=%b d=%h csx=%b required dcx=%b d=%h csx=0 at cyc=%0d",
                       cyc, bus.lcd_dcx, bus.lcd_d, bus.lcd_csx, e.dcx, e.data, e.cyc);
          end
        end
      end
      prev_low  = (bus.lcd_wrx === 1'b0);
      prev_byte = {bus.lcd_dcx, bus.lcd_d};
      if (bus.cmd_done === 1'b1) begin
        checks++;
        if (exp_d.size() == 0) begin
          failures++;
          if (failures <= 40) $display("FAIL unexpected_done cyc=%0d got cmd_done=1 required 0", cyc);
        end else begin
          int t;
          t = exp_d.pop_front();
          if (t != cyc || bus.busy !== 1'b1 || bus.lcd_csx !== 1'b1) begin
            failures++;
            if (failures <= 40)
              $display("FAIL cmd_done cyc=%0d busy=%b csx=%b required cyc=%0d busy=1 csx=1",
                       cyc, bus.busy, bus.lcd_csx, t);
          end
        end
      end
      while (exp_b.size() > 0 && exp_b[0].cyc < cyc) begin
        checks++;
        failures++;
        if (failures <= 40)
          $display("FAIL missing_byte cyc=%0d got no strobe required d=%h at cyc=%0d", cyc, exp_b[0].data, exp_b[0].cyc);
        void'(exp_b.pop_front());
      end
      while (exp_d.size() > 0 && exp_d[0] < cyc) begin
        checks++;
        failures++;
        if (failures <= 40)
          $display("FAIL missing_done cyc=%0d got no cmd_done required at cyc=%0d", cyc, exp_d[0]);
        void'(exp_d.pop_front());
      end
    end
  end

  // Issue one request; optionally disturb inputs mid-paint or reset after N bytes.
  task automatic paint(input int px, input int py, input int obj, input bit disturb, input int rst_after);
    int  start_bytes;
    bit  fin;
    bus.x        = 4'(px);
    bus.y        = 4'(py);
    bus.obj_code = 3'(obj);
    bus.diff     = 1'b1;
    model(px, py, obj, cyc);
    start_bytes = bytes_seen;
    fin = 1'b0;
    for (int i = 0; i < 4000 && !fin; i++) begin
      @(negedge clk); #1;
      if (bus.cmd_done === 1'b1) begin
        fin = 1'b1;
      end else if (rst_after > 0 && (bytes_seen - start_bytes) >= rst_after) begin
        rst      = 1'b1;
        bus.diff = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;
        fin = 1'b1;
      end else if (disturb && i > 4 && (i % 37) == 0) begin
        bus.x        = 4'($urandom);
        bus.y        = 4'($urandom);
        bus.obj_code = 3'($urandom);
        bus.diff     = ~bus.diff;
      end
    end
    bus.diff = 1'b0;
    repeat (1 + $urandom_range(0, 3)) begin
      @(negedge clk); #1;
    end
  endtask

  initial begin
    bus.diff     = 1'b0;
    bus.x        = 4'd0;
    bus.y        = 4'd0;
    bus.obj_code = 3'd0;
    repeat (4) @(negedge clk);
    #1 rst = 1'b0;
    repeat (10) begin
      @(negedge clk); #1;
    end

    paint(4, 4, 2, 1'b0, 0);
    paint(15, 11, 4, 1'b0, 0);
    paint(12, 3, 3, 1'b0, 0);
    paint(3, 12, 1, 1'b0, 0);
    paint(15, 15, 2, 1'b0, 0);
    paint(7, 5, 1, 1'b1, 0);
    paint(2, 9, 3, 1'b0, 300);
    paint(2, 9, 3, 1'b0, 0);
    paint(0, 0, 0, 1'b0, 0);
    for (int n = 0; n < 6; n++) begin
      paint($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7), n[0], 0);
    end

    repeat (20) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
